spi_sram_ctrl: RTL
==================

SPI_SRAM_CTRL -- requirements
Module: spi_sram_ctrl

Interface
REQ-001 SHALL have parameter SCK_HALF, default 1, clk cycles per SCK half-period (legal 1..16).
REQ-002 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low; clock clk.
REQ-004 SHALL have ena  input  1  global enable; low freezes all state.
REQ-005 SHALL have req_valid  input  1  request present.
REQ-006 SHALL have req_ready  output  1  controller can accept a request.
REQ-007 SHALL have req_write  input  1  1 = byte write, 0 = byte read.
REQ-008 SHALL have req_addr  input  24  SRAM byte address.
REQ-009 SHALL have req_wdata  input  8  write data.
REQ-010 SHALL have rsp_valid  output  1  one-cycle completion pulse (reads and writes).
REQ-011 SHALL have rsp_rdata  output  8  read data, valid while rsp_valid=1.
REQ-012 SHALL have sram_cs_n  output  1  SRAM chip select, active-low.
REQ-013 SHALL have sram_sck  output  1  SPI clock, mode 0.
REQ-014 SHALL have sram_si  output  1  MOSI.
REQ-015 SHALL have sram_so  input  1  MISO.

Function
REQ-016 SHALL implement states IDLE, SHIFT, DONE; IDLE->SHIFT on accept, SHIFT->DONE after bit 39, DONE->IDLE unconditionally.
REQ-017 SHALL assert req_ready only in IDLE with ena=1; accept = req_valid & req_ready at a clk edge; requests are ignored in every other state.
REQ-018 SHALL, on accept, latch req_write/addr/wdata into a 40-bit frame {opcode, addr[23:0], data[7:0]}; opcode 0x02 for write, 0x03 for read; read data field is don't-care.
REQ-019 SHALL, in the cycle after accept, drive sram_cs_n=0, sram_sck=0, sram_si=frame bit 39; frame is shifted MSB-first.
REQ-020 SHALL hold each bit SCK_HALF cycles with sck low, then SCK_HALF cycles with sck high; sram_si changes only at sck falling transitions (and at SHIFT entry).
REQ-021 SHALL sample sram_so at the clk edge where sram_sck goes 0->1, for bits 32..39 only, shifting into rsp_rdata MSB-first.
REQ-022 SHALL, after bit 39's high phase, enter DONE with sram_cs_n=1, sram_sck=0, rsp_valid=1 for exactly one cycle.
REQ-023 SHALL yield latency: rsp_valid visible 80*SCK_HALF+1 cycles after the accept edge; req_ready high again one cycle later.
REQ-024 SHALL keep sram_cs_n high for at least 2 cycles between transactions (DONE + IDLE).
REQ-025 SHALL use a 6-bit bit counter (0..39) and a divider counter of width clog2(SCK_HALF)+1; no counter wraps within a transaction.
REQ-026 SHALL, with ena=0, hold every register and output unchanged, rsp_valid included; transaction resumes exactly where frozen.
REQ-027 SHALL drive rsp_rdata=0x00 on write completions.

Reset
REQ-028 SHALL, when rst_n=0 at a clk edge (regardless of ena), set state=IDLE, sram_cs_n=1, sram_sck=0, sram_si=0, rsp_valid=0, rsp_rdata=0x00, counters=0.
REQ-029 SHALL abort any in-flight transaction on reset with no rsp_valid; req_ready=1 in the first cycle after rst_n rises with ena=1.

Structure
REQ-030 SHALL place CMD_READ=8'h03, CMD_WRITE=8'h02, ADDR_W=24, and the state enum in shared package spi_sram_pkg.
REQ-031 SHALL isolate SCK generation (divider, rise/fall strobes) in sub-module spi_sram_sck_gen.

Verification
REQ-032 SHALL test write 0x5A @0x012345, SCK_HALF=1 -> SI bytes 02 01 23 45 5A MSB-first, 40 sck rises, cs_n low exactly 80 cycles, rsp_valid at cycle 81.
REQ-033 SHALL test read @0xFFFFFF, SO model returns 0xA5 -> SI bytes 03 FF FF FF, rsp_rdata=0xA5 with rsp_valid.
REQ-034 SHALL test rst_n=0 during bit 20 -> next cycle cs_n=1, sck=0; no rsp_valid; req_ready=1 after release.
REQ-035 SHALL test ena=0 for 10 cycles mid-SHIFT -> outputs frozen; rsp_valid at cycle 91.
REQ-036 SHALL test req_valid held high for two back-to-back reads -> second accept at cycle 82, cs_n high 2 cycles between frames.
REQ-037 SHALL test SCK_HALF=3 write -> sck period 6 cycles, rsp_valid at cycle 241.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// ============================================================================
//  Module   : spi_sram_pkg
//  Purpose  : Shared opcodes, widths, FSM encoding and frame builder for the
//             SPI SRAM byte controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int         ADDR_W    = 24;
  localparam int         DATA_W    = 8;
  localparam int         FRAME_W   = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Read frames carry a zero data byte; the slave ignores it.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              wr,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    return {(wr ? CMD_WRITE : CMD_READ), addr, (wr ? wdata : 8'h00)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sram_ctrl_if.sv
// ============================================================================
//  Module   : spi_sram_ctrl_if
//  Purpose  : Request/response bus between a client and the SPI SRAM
//             controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_sram_ctrl_if;
  import spi_sram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/spi_sram_sck_gen.sv
// ============================================================================
//  Module   : spi_sram_sck_gen
//  Purpose  : Mode-0 SPI clock divider; flags the clk edges on which SCK
//             rises and falls so the shifter can act on them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sram_sck_gen #(
  parameter int SCK_HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int               DIV_W      = $clog2(SCK_HALF) + 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCK_HALF - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_sck;
  logic             w_phase_end;

  assign w_phase_end = run && (r_div == c_div_last);
  assign rise        = w_phase_end && !r_sck;
  assign fall        = w_phase_end && r_sck;
  assign sck         = r_sck;

  // Outside a frame the divider is parked at zero so every frame starts
  // with a full low half-period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_sck <= 1'b0;
    end else if (ena) begin
      if (!run) begin
        r_div <= '0;
        r_sck <= 1'b0;
      end else if (w_phase_end) begin
        r_div <= '0;
        r_sck <= ~r_sck;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_sram_ctrl.sv
// ============================================================================
//  Module   : spi_sram_ctrl
//  Purpose  : Single-byte read/write controller for a 24-bit-address SPI
//             SRAM, issuing one 40-bit mode-0 frame per request.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sram_ctrl
  import spi_sram_pkg::*;
#(
  parameter int SCK_HALF = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  spi_sram_ctrl_if.slave  bus,
  output logic            sram_cs_n,
  output logic            sram_sck,
  output logic            sram_si,
  input  logic            sram_so
);

  state_t              r_state;
  logic [FRAME_W-1:0]  r_frame;
  logic [5:0]          r_bit;
  logic                r_write;
  logic                r_cs_n;
  logic                r_si;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_run;
  logic                w_rise;
  logic                w_fall;
  logic                w_accept;
  logic [FRAME_W-1:0]  w_frame;

  assign bus.req_ready = rst_n && ena && (r_state == ST_IDLE);
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_run         = (r_state == ST_SHIFT);
  assign w_frame       = build_frame(bus.req_write, bus.req_addr, bus.req_wdata);

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign sram_cs_n     = r_cs_n;
  assign sram_si       = r_si;

  spi_sram_sck_gen #(
    .SCK_HALF (SCK_HALF)
  ) u_sck_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .run   (w_run),
    .sck   (sram_sck),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_frame     <= '0;
      r_bit       <= '0;
      r_write     <= 1'b0;
      r_cs_n      <= 1'b1;
      r_si        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else if (ena) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SHIFT;
            r_frame <= w_frame;
            r_si    <= w_frame[FRAME_W-1];
            r_bit   <= '0;
            r_write <= bus.req_write;
            r_cs_n  <= 1'b0;
            r_rdata <= '0;
          end
        end
        ST_SHIFT: begin
          // Only the trailing data byte of a read carries slave output.
          if (w_rise && !r_write && (r_bit >= 6'd32))
            r_rdata <= {r_rdata[DATA_W-2:0], sram_so};
          if (w_fall) begin
            if (r_bit == 6'd39) begin
              r_state     <= ST_DONE;
              r_cs_n      <= 1'b1;
              r_si        <= 1'b0;
              r_rsp_valid <= 1'b1;
            end else begin
              r_bit   <= r_bit + 6'd1;
              r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
              r_si    <= r_frame[FRAME_W-2];
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
